// File: rtl/rv_pkg.sv
// Shared RV32 encoding constants: format codes, opcodes, immediate limits, field bundle.
package rv_pkg;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned REG_W     = 5;
    localparam int unsigned F3_W      = 3;
    localparam int unsigned OPC_W     = 7;
    localparam int unsigned FMT_W     = 2;
    localparam int unsigned ERR_CNT_W = 8;

    typedef enum logic [FMT_W-1:0] {
        FMT_LOAD    = 2'd0,
        FMT_ALU_IMM = 2'd1,
        FMT_STORE   = 2'd2,
        FMT_BRANCH  = 2'd3
    } fmt_e;

    localparam logic [OPC_W-1:0] OPC_LOAD    = 7'b0000011;
    localparam logic [OPC_W-1:0] OPC_ALU_IMM = 7'b0010011;
    localparam logic [OPC_W-1:0] OPC_STORE   = 7'b0100011;
    localparam logic [OPC_W-1:0] OPC_BRANCH  = 7'b1100011;

    // Signed immediate limits: 12-bit I/S, 13-bit even B offset
    localparam int IMM_IS_MIN = -2048;
    localparam int IMM_IS_MAX = 2047;
    localparam int IMM_B_MIN  = -4096;
    localparam int IMM_B_MAX  = 4094;

    typedef struct packed {
        fmt_e              fmt;
        logic [REG_W-1:0]  rd;
        logic [REG_W-1:0]  rs1;
        logic [REG_W-1:0]  rs2;
        logic [F3_W-1:0]   funct3;
        logic [XLEN-1:0]   imm;
    } fields_t;

    // True when imm is representable in the given format's immediate field
    function automatic logic imm_in_range(fmt_e fmt, logic [XLEN-1:0] imm);
        int v;
        v = int'($signed(imm));
        if (fmt == FMT_BRANCH) begin
            return (v >= IMM_B_MIN) && (v <= IMM_B_MAX) && !imm[0];
        end
        return (v >= IMM_IS_MIN) && (v <= IMM_IS_MAX);
    endfunction

endpackage

// File: rtl/instr_pack.sv
// Pure field-to-word mapping for I/S/B instruction formats.
module instr_pack
    import rv_pkg::*;
(
    input  fields_t           fields,
    output logic [XLEN-1:0]   instr_c
);

    // Immediate bits above the widest field are never encoded
    logic unused_imm_c;
    assign unused_imm_c = ^fields.imm[XLEN-1:13];

    // Place each field at its format-specific bit position
    always_comb begin
        instr_c = '0;
        case (fields.fmt)
            FMT_LOAD:    instr_c = {fields.imm[11:0], fields.rs1, fields.funct3, fields.rd, OPC_LOAD};
            FMT_ALU_IMM: instr_c = {fields.imm[11:0], fields.rs1, fields.funct3, fields.rd, OPC_ALU_IMM};
            FMT_STORE:   instr_c = {fields.imm[11:5], fields.rs2, fields.rs1, fields.funct3,
                                    fields.imm[4:0], OPC_STORE};
            FMT_BRANCH:  instr_c = {fields.imm[12], fields.imm[10:5], fields.rs2, fields.rs1,
                                    fields.funct3, fields.imm[4:1], fields.imm[11], OPC_BRANCH};
            default:     instr_c = '0;
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// Instruction encoder: one-deep output register with address counter.
// Optional immediate range rejection enabled by defining IMM_RANGE_CHECK_EN.
module instr_encoder
    import rv_pkg::*;
#(
    parameter int unsigned       ADDR_W    = 8,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [FMT_W-1:0]      in_fmt,
    input  logic [REG_W-1:0]      in_rd,
    input  logic [REG_W-1:0]      in_rs1,
    input  logic [REG_W-1:0]      in_rs2,
    input  logic [F3_W-1:0]       in_funct3,
    input  logic [XLEN-1:0]       in_imm,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [XLEN-1:0]       out_instr,
    output logic [ADDR_W-1:0]     out_addr,
    output logic                  err,
    output logic [ERR_CNT_W-1:0]  err_count
);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_e;

    state_e              state_q, state_d;
    logic [XLEN-1:0]     instr_q, instr_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic [ADDR_W-1:0]   base_c;
    logic                accept_c, take_c, emit_c, reject_c;
    fields_t             fields_c;
    logic [XLEN-1:0]     pack_instr_c;

    assign fields_c = '{fmt: fmt_e'(in_fmt), rd: in_rd, rs1: in_rs1, rs2: in_rs2,
                        funct3: in_funct3, imm: in_imm};

    instr_pack u_pack (
        .fields  (fields_c),
        .instr_c (pack_instr_c)
    );

    assign in_ready = (state_q == EMPTY) || out_ready;
    assign accept_c = in_valid && in_ready;
    assign take_c   = (state_q == FULL) && out_ready;

`ifdef IMM_RANGE_CHECK_EN
    logic                 err_q, err_d;
    logic [ERR_CNT_W-1:0] err_count_q, err_count_d;

    assign reject_c = accept_c && !imm_in_range(fmt_e'(in_fmt), in_imm);

    // Rejection pulse and saturating rejection count
    always_comb begin
        err_d       = reject_c;
        err_count_d = err_count_q;
        if (reject_c && (err_count_q != {ERR_CNT_W{1'b1}})) begin
            err_count_d = err_count_q + ERR_CNT_W'(1);
        end
    end

    // Error registers
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q       <= 1'b0;
            err_count_q <= '0;
        end else begin
            err_q       <= err_d;
            err_count_q <= err_count_d;
        end
    end

    assign err       = err_q;
    assign err_count = err_count_q;
`else
    assign reject_c  = 1'b0;
    assign err       = 1'b0;
    assign err_count = '0;
`endif

    assign emit_c = accept_c && !reject_c;

    // Next state, output word capture and address counter update
    always_comb begin
        state_d = state_q;
        instr_d = instr_q;
        addr_d  = addr_q;
        base_c  = clear ? BASE_ADDR : cnt_q;
        cnt_d   = base_c;
        if (emit_c) begin
            instr_d = pack_instr_c;
            addr_d  = base_c;
            cnt_d   = base_c + ADDR_W'(4);
        end
        case (state_q)
            EMPTY:   if (emit_c) state_d = FULL;
            FULL:    if (take_c && !emit_c) state_d = EMPTY;
            default: state_d = EMPTY;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            instr_q <= '0;
            addr_q  <= BASE_ADDR;
            cnt_q   <= BASE_ADDR;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign out_valid = (state_q == FULL);
    assign out_instr = instr_q;
    assign out_addr  = addr_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder (range-check tests active when IMM_RANGE_CHECK_EN is defined).
module tb_instr_encoder;

    localparam int BASE = 0;

`ifdef IMM_RANGE_CHECK_EN
    localparam bit CHECK_EN = 1'b1;
`else
    localparam bit CHECK_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, clear, in_valid, in_ready, out_valid, out_ready, err;
    logic [1:0]  in_fmt;
    logic [4:0]  in_rd, in_rs1, in_rs2;
    logic [2:0]  in_funct3;
    logic [31:0] in_imm, out_instr;
    logic [7:0]  out_addr, err_count;

    always #5 clk = ~clk;

    instr_encoder #(.ADDR_W(8), .BASE_ADDR(8'(BASE))) dut (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_fmt    (in_fmt),
        .in_rd     (in_rd),
        .in_rs1    (in_rs1),
        .in_rs2    (in_rs2),
        .in_funct3 (in_funct3),
        .in_imm    (in_imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .out_addr  (out_addr),
        .err       (err),
        .err_count (err_count)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: pending-word queue, address counter, error tally
    logic [31:0] q_instr[$];
    int          q_addr[$];
    int          m_cnt    = BASE;
    int          m_errcnt = 0;
    bit          m_err    = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_encode(int fmt, int rd, int rs1, int rs2, int f3, int imm);
        logic [31:0] u, op, w;
        logic [31:0] ops [4];
        ops = '{32'h03, 32'h13, 32'h23, 32'h63};
        u  = imm;
        op = ops[fmt];
        case (fmt)
            0, 1: w = ((u & 32'hFFF) << 20) | (32'(rs1) << 15) | (32'(f3) << 12) | (32'(rd) << 7) | op;
            2:    w = (((u >> 5) & 32'h7F) << 25) | (32'(rs2) << 20) | (32'(rs1) << 15)
                      | (32'(f3) << 12) | ((u & 32'h1F) << 7) | op;
            default: w = (((u >> 12) & 32'h1) << 31) | (((u >> 5) & 32'h3F) << 25)
                      | (32'(rs2) << 20) | (32'(rs1) << 15) | (32'(f3) << 12)
                      | (((u >> 1) & 32'hF) << 8) | (((u >> 11) & 32'h1) << 7) | op;
        endcase
        return w;
    endfunction

    function automatic bit ref_reject(int fmt, int imm);
        if (!CHECK_EN) return 1'b0;
        if (fmt == 3) return (imm < -4096) || (imm > 4094) || (imm % 2 != 0);
        return (imm < -2048) || (imm > 2047);
    endfunction

    // One clock: drive at negedge, predict, then compare after the rising edge
    task automatic step(input bit v, input int fmt, input int rd, input int rs1, input int rs2,
                        input int f3, input int imm, input bit ordy, input bit clr, input bit r);
        bit exp_rdy, acc, tk;
        int base;
        @(negedge clk);
        rst       = r;
        clear     = clr;
        in_valid  = v;
        in_fmt    = 2'(fmt);
        in_rd     = 5'(rd);
        in_rs1    = 5'(rs1);
        in_rs2    = 5'(rs2);
        in_funct3 = 3'(f3);
        in_imm    = imm;
        out_ready = ordy;
        #1;
        exp_rdy = (q_instr.size() == 0) || ordy;
        check("in_ready", 32'(in_ready), 32'(exp_rdy));
        acc = v && exp_rdy;
        tk  = (q_instr.size() != 0) && ordy;
        @(posedge clk);
        #1;
        if (r) begin
            q_instr.delete();
            q_addr.delete();
            m_cnt    = BASE;
            m_errcnt = 0;
            m_err    = 1'b0;
            check("rst_instr", out_instr, 32'h0);
            check("rst_addr", 32'(out_addr), 32'(BASE));
        end else begin
            m_err = 1'b0;
            if (tk) begin
                void'(q_instr.pop_front());
                void'(q_addr.pop_front());
            end
            base = clr ? BASE : m_cnt;
            if (acc && ref_reject(fmt, imm)) begin
                m_err = 1'b1;
                if (m_errcnt < 255) m_errcnt++;
                m_cnt = base;
            end else if (acc) begin
                q_instr.push_back(ref_encode(fmt, rd, rs1, rs2, f3, imm));
                q_addr.push_back(base);
                m_cnt = (base + 4) % 256;
            end else begin
                m_cnt = base;
            end
        end
        check("out_valid", 32'(out_valid), 32'(q_instr.size() != 0));
        if (q_instr.size() != 0) begin
            check("out_instr", out_instr, q_instr[0]);
            check("out_addr", 32'(out_addr), 32'(q_addr[0]));
        end
        check("err", 32'(err), 32'(m_err));
        check("err_count", 32'(err_count), 32'(m_errcnt));
    endtask

    task automatic do_reset();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    endtask

    initial begin
        int fmt, imm, sel;
        rst = 1'b1; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_fmt = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_funct3 = '0; in_imm = '0;

        // Reset state
        do_reset();
        check("reset_valid", 32'(out_valid), 32'h0);
        check("reset_err_count", 32'(err_count), 32'h0);

        // addi x5, x0, -1
        step(1, 1, 5, 0, 0, 0, -1, 1, 0, 0);
        check("addi_instr", out_instr, 32'hFFF00293);
        check("addi_addr", 32'(out_addr), 32'h00);
        step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);

        // Back-to-back store then load
        do_reset();
        step(1, 2, 0, 2, 6, 2, 8, 1, 0, 0);
        check("sw_instr", out_instr, 32'h00612423);
        check("sw_addr", 32'(out_addr), 32'h00);
        step(1, 0, 10, 11, 0, 2, 16, 1, 0, 0);
        check("lw_instr", out_instr, 32'h0105A503);
        check("lw_addr", 32'(out_addr), 32'h04);
        step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);

        // Branch with stalled consumer: word holds, input blocked
        do_reset();
        step(1, 3, 0, 1, 2, 0, -4, 1, 0, 0);
        check("beq_instr", out_instr, 32'hFE208EE3);
        for (int i = 0; i < 3; i++) begin
            step(1, 1, 7, 7, 7, 1, 100, 0, 0, 0);
            check("stall_instr", out_instr, 32'hFE208EE3);
            check("stall_ready", 32'(in_ready), 32'h0);
        end
        step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);

`ifdef IMM_RANGE_CHECK_EN
        // Out-of-range immediate rejected without consuming an address
        do_reset();
        step(1, 1, 1, 1, 0, 0, 2048, 1, 0, 0);
        check("rej_err", 32'(err), 32'h1);
        check("rej_count", 32'(err_count), 32'h1);
        check("rej_valid", 32'(out_valid), 32'h0);
        step(1, 1, 1, 1, 0, 0, 5, 1, 0, 0);
        check("rej_err_pulse", 32'(err), 32'h0);
        check("rej_next_addr", 32'(out_addr), 32'h00);
        step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
`endif

        // Address wrap after 64 words
        do_reset();
        for (int i = 0; i < 64; i++) begin
            step(1, int'($urandom_range(0, 3)), int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                 int'($urandom_range(0, 31)), int'($urandom_range(0, 7)), int'($urandom_range(0, 1000)) * 2,
                 1, 0, 0);
        end
        check("wrap_last_addr", 32'(out_addr), 32'hFC);
        step(1, 1, 3, 3, 0, 0, 12, 1, 0, 0);
        check("wrap_next_addr", 32'(out_addr), 32'h00);

        // Clear with accept, then reset while full
        do_reset();
        for (int i = 0; i < 3; i++) step(1, 0, i, i, 0, 2, 4 * i, 1, 0, 0);
        check("pre_clear_addr", 32'(out_addr), 32'h08);
        step(1, 2, 0, 3, 4, 2, 20, 1, 1, 0);
        check("clear_addr", 32'(out_addr), 32'(BASE));
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        check("full_before_rst", 32'(out_valid), 32'h1);
        step(1, 0, 1, 1, 1, 0, 0, 0, 0, 1);
        check("rst_drops_word", 32'(out_valid), 32'h0);

        // Randomised traffic against the model
        do_reset();
        for (int i = 0; i < 600; i++) begin
            fmt = int'($urandom_range(0, 3));
            sel = int'($urandom_range(0, 3));
            if (sel == 0) imm = int'($urandom);
            else imm = int'($urandom_range(0, 10000)) - 5000;
            step(bit'($urandom_range(0, 3) != 0), fmt, int'($urandom_range(0, 31)),
                 int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), int'($urandom_range(0, 7)),
                 imm, bit'($urandom_range(0, 2) != 0), bit'($urandom_range(0, 9) == 0),
                 bit'($urandom_range(0, 79) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, the byte-address width of out_addr.
REQ-002 SHALL have parameter BASE_ADDR, default 0, the first byte address issued after reset or clear.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port clear, input, 1, reload the address counter to BASE_ADDR.
REQ-006 SHALL have port in_valid, input, 1, field set presented.
REQ-007 SHALL have port in_ready, output, 1, field set accepted when in_valid && in_ready.
REQ-008 SHALL have port in_fmt, input, 2, format: 0=load (0000011), 1=alu-imm (0010011), 2=store (0100011), 3=branch (1100011).
REQ-009 SHALL have ports in_rd, in_rs1 and in_rs2, input, 5 each, register fields.
REQ-010 SHALL have port in_funct3, input, 3, funct3 field.
REQ-011 SHALL have port in_imm, input, 32, signed immediate (byte offset for branch).
REQ-012 SHALL have port out_valid, output, 1, encoded word pending.
REQ-013 SHALL have port out_ready, input, 1, consumer takes word when out_valid && out_ready.
REQ-014 SHALL have port out_instr, output, 32, encoded instruction.
REQ-015 SHALL have port out_addr, output, ADDR_W, byte address of out_instr.
REQ-016 SHALL have port err, output, 1, one-cycle pulse on rejected field set.
REQ-017 SHALL have port err_count, output, 8, saturating count of rejections.

Function
REQ-018 SHALL encode I-type as {imm[11:0], rs1, funct3, rd, opcode}, S-type as {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}, and B-type as {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}; unused fields are ignored.
REQ-019 SHALL use a two-state output FSM: EMPTY and FULL. EMPTY goes to FULL on accept. FULL stays FULL on simultaneous take and accept. FULL goes to EMPTY on take without accept.
REQ-020 SHALL drive in_ready = (state==EMPTY) || out_ready, combinationally, with no dependence on in_valid.
REQ-021 SHALL present an accepted word on out_instr/out_addr in the cycle after accept (latency 1), and hold it stable while out_valid && !out_ready.
REQ-022 SHALL assign each emitted word the current address and then advance the counter by 4, wrapping modulo 2^ADDR_W.
REQ-023 SHALL make clear reload the counter to BASE_ADDR without disturbing any pending word; on clear coincident with accept, the accepted word takes BASE_ADDR and the counter becomes BASE_ADDR+4.

Reset
REQ-024 SHALL, on rst: state=EMPTY, out_valid=0, out_instr=0, out_addr=BASE_ADDR, counter=BASE_ADDR, err=0, err_count=0.
REQ-025 SHALL make rst dominate clear and any handshake in the same cycle; a word pending at reset is discarded.

Configuration
REQ-026 SHALL, with IMM_RANGE_CHECK_EN defined, reject a field set whose immediate is out of range: I/S outside -2048..2047; B outside -4096..4094 or odd.
REQ-027 SHALL, on such a rejection, still assert in_ready and accept the set, but emit no word, leave the counter unchanged, pulse err, and increment err_count (saturating at 255).
REQ-028 SHALL, without IMM_RANGE_CHECK_EN, silently truncate immediates, tie err and err_count to 0, and include no range-check logic.

Structure
REQ-029 SHALL take format codes, the four opcode constants and the immediate range limits from shared package rv_pkg, which the decode side also uses.
REQ-030 SHALL place the pure field-to-word mapping in combinational sub-module instr_pack, leaving the handshake, counter and error logic in instr_encoder.

Verification
REQ-031 SHALL check: fmt=1, rd=5, rs1=0, f3=0, imm=-1 -> out_instr=0xFFF00293, out_addr=0x00.
REQ-032 SHALL check: back-to-back fmt=2 (rs1=2, rs2=6, f3=2, imm=8) then fmt=0 (rd=10, rs1=11, f3=2, imm=16) -> 0x00612423 @0x00, then 0x0105A503 @0x04.
REQ-033 SHALL check: fmt=3, rs1=1, rs2=2, f3=0, imm=-4 -> 0xFE208EE3; out_ready held low for 3 cycles -> word stable, in_ready=0.
REQ-034 SHALL check, with IMM_RANGE_CHECK_EN: fmt=1, imm=2048 -> err pulses once, err_count=1, no out_valid, next word still @0x00.
REQ-035 SHALL check: 64 words with ADDR_W=8 -> the 64th word at 0xFC; the next word at 0x00.
REQ-036 SHALL check: clear coincident with accept after 3 words -> word @BASE_ADDR; rst asserted while FULL -> out_valid=0 on the next cycle.
